// File: rtl/mult_div_sequencer.sv
// Iterative multiply/divide unit for the EX stage: owns HI/LO, runs a one-bit-per-cycle
// shift-add multiplier and restoring divider, and raises mult_div_stall while busy.
module mult_div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             hilo_read,
    input  logic             hilo_sel,
    input  logic             flush,
    output logic [WIDTH-1:0] hilo_rdata,
    output logic             busy,
    output logic             mult_div_stall,
    output logic             done,
    output logic             div_by_zero
);

    localparam int            CW        = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t             state;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   quo;
    logic [2*WIDTH:0]   acc;
    logic [WIDTH:0]     rem;
    logic [CW-1:0]      cnt;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;

    logic               signed_op;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH+1:0]   div_shift;
    logic [WIDTH+1:0]   div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    // div_shift keeps one extra top bit so a negative trial difference shows up in div_diff's MSB
    always_comb begin
        signed_op = (op == OP_MULT) || (op == OP_DIV);
        a_neg     = signed_op & rs_val[WIDTH-1];
        b_neg     = signed_op & rt_val[WIDTH-1];
        abs_a     = a_neg ? -rs_val : rs_val;
        abs_b     = b_neg ? -rt_val : rt_val;
        mul_sum   = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, opnd} : '0);
        div_shift = {rem, quo[WIDTH-1]};
        div_diff  = div_shift - {2'b00, opnd};
        prod_fix  = neg_q ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
        quo_fix   = neg_q ? -quo : quo;
        rem_fix   = neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
    end

    assign hilo_rdata     = hilo_sel ? hi : lo;
    assign mult_div_stall = busy & (start | hilo_read);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            hi          <= '0;
            lo          <= '0;
            opnd        <= '0;
            quo         <= '0;
            acc         <= '0;
            rem         <= '0;
            cnt         <= '0;
            is_div      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !flush && (op <= OP_MTLO)) begin
                        div_by_zero <= 1'b0;
                        cnt         <= '0;
                        neg_q       <= a_neg ^ b_neg;
                        neg_r       <= a_neg;
                        case (op)
                            OP_MTHI: hi <= rs_val;
                            OP_MTLO: lo <= rs_val;
                            OP_MULT, OP_MULTU: begin
                                acc    <= {{(WIDTH+1){1'b0}}, abs_b};
                                opnd   <= abs_a;
                                is_div <= 1'b0;
                                busy   <= 1'b1;
                                state  <= MUL;
                            end
                            default: begin
                                // A zero divisor finishes immediately with the architected fill values
                                if (rt_val == '0) begin
                                    hi          <= rs_val;
                                    lo          <= '1;
                                    div_by_zero <= 1'b1;
                                    done        <= 1'b1;
                                end else begin
                                    rem    <= '0;
                                    quo    <= abs_a;
                                    opnd   <= abs_b;
                                    is_div <= 1'b1;
                                    busy   <= 1'b1;
                                    state  <= DIV;
                                end
                            end
                        endcase
                    end
                end
                MUL, DIV: begin
                    if (flush) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        if (state == MUL) begin
                            acc <= {1'b0, mul_sum, acc[WIDTH-1:1]};
                        end else begin
                            rem <= div_diff[WIDTH+1] ? div_shift[WIDTH:0] : div_diff[WIDTH:0];
                            quo <= {quo[WIDTH-2:0], ~div_diff[WIDTH+1]};
                        end
                        cnt <= cnt + CW'(1);
                        if (cnt == LAST_ITER) begin
                            state <= FIX;
                            done  <= 1'b1;
                        end
                    end
                end
                FIX: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                    if (!flush) begin
                        if (is_div) begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end else begin
                            hi <= prod_fix[2*WIDTH-1:WIDTH];
                            lo <= prod_fix[WIDTH-1:0];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Directed bench for mult_div_sequencer: a queue of expected {HI,LO} values is filled
// when ops are driven and drained when the DUT signals completion.
module tb_mult_div_sequencer;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        hilo_read;
    logic        hilo_sel;
    logic        flush;
    logic [31:0] hilo_rdata;
    logic        busy;
    logic        mult_div_stall;
    logic        done;
    logic        div_by_zero;

    int          vectors = 0;
    int          miscompares = 0;
    logic [63:0] exp_q[$];
    logic [31:0] last_hi = 32'h0;
    logic [31:0] last_lo = 32'h0;

    mult_div_sequencer #(.WIDTH(32)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .op             (op),
        .rs_val         (rs_val),
        .rt_val         (rt_val),
        .hilo_read      (hilo_read),
        .hilo_sel       (hilo_sel),
        .flush          (flush),
        .hilo_rdata     (hilo_rdata),
        .busy           (busy),
        .mult_div_stall (mult_div_stall),
        .done           (done),
        .div_by_zero    (div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference {HI,LO} using the simulator's own wide arithmetic
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, q, r;
        logic [31:0] uq, ur;
        sa = 64'($signed(a));
        sb = 64'($signed(b));
        case (o)
            OP_MULT:  model = sa * sb;
            OP_MULTU: model = {32'h0, a} * {32'h0, b};
            OP_DIV: begin
                if (b == 32'h0) model = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    model = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'h0) model = {a, 32'hFFFF_FFFF};
                else begin
                    uq = a / b;
                    ur = a % b;
                    model = {ur, uq};
                end
            end
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input bit push);
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        if (push && (o <= OP_DIVU)) exp_q.push_back(model(o, a, b));
    endtask

    // Called in the done cycle: results must be readable one cycle later
    task automatic check_output(input string tag);
        logic [63:0] e;
        tick();
        check_value({tag, " done pulse"}, 32'(done), 32'd0);
        check_value({tag, " busy after"}, 32'(busy), 32'd0);
        check_value({tag, " queue"}, 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            hilo_sel = 1'b0;
            #1;
            check_value({tag, " lo"}, hilo_rdata, e[31:0]);
            hilo_sel = 1'b1;
            #1;
            check_value({tag, " hi"}, hilo_rdata, e[63:32]);
            hilo_sel = 1'b0;
            last_hi = e[63:32];
            last_lo = e[31:0];
        end
    endtask

    task automatic finish_op(input string tag);
        int waited = 0;
        while (done !== 1'b1 && waited < 40) begin
            tick();
            waited++;
        end
        check_value({tag, " done seen"}, 32'(done), 32'd1);
        if (done === 1'b1) check_output(tag);
        else if (exp_q.size() > 0) void'(exp_q.pop_front());
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
        apply_stimulus(o, a, b, 1'b1);
        tick();
        start = 1'b0;
        finish_op(tag);
    endtask

    initial begin
        logic [63:0] e;
        reset_n   = 1'b0;
        start     = 1'b0;
        op        = 3'd0;
        rs_val    = 32'h0;
        rt_val    = 32'h0;
        hilo_read = 1'b0;
        hilo_sel  = 1'b0;
        flush     = 1'b0;
        tick();
        tick();
        check_value("reset lo", hilo_rdata, 32'h0);
        check_value("reset busy", 32'(busy), 32'd0);
        check_value("reset done", 32'(done), 32'd0);
        check_value("reset stall", 32'(mult_div_stall), 32'd0);
        check_value("reset dbz", 32'(div_by_zero), 32'd0);
        reset_n = 1'b1;
        tick();

        // Test 1: MULT -3 * 7 with cycle-exact busy/done
        apply_stimulus(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b1);
        tick();
        start = 1'b0;
        for (int c = 1; c <= 33; c++) begin
            check_value($sformatf("t1 busy c%0d", c), 32'(busy), 32'd1);
            check_value($sformatf("t1 done c%0d", c), 32'(done), 32'(c == 33));
            if (c < 33) tick();
        end
        check_output("t1 mult");

        // Test 2: signed/unsigned corner cases and a few random ops
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "t2 multu max");
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,         "t2 div -7/2");
        run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, "t2 div ovf");
        run_op(OP_DIV,   32'd7,         32'hFFFF_FFFE, "t2 div 7/-2");
        run_op(OP_MULT,  32'h8000_0000, 32'h8000_0000, "t2 mult minmin");
        run_op(OP_DIVU,  32'hFFFF_FFFF, 32'd7,         "t2 divu");
        for (int i = 0; i < 6; i++) begin
            run_op(3'($urandom_range(0, 3)), $urandom, (i % 2) ? $urandom : 32'($urandom_range(1, 300)),
                   $sformatf("t2 rand%0d", i));
        end

        // Test 3: divide by zero completes immediately; next start clears the flag
        apply_stimulus(OP_DIVU, 32'd100, 32'd0, 1'b1);
        tick();
        start = 1'b0;
        check_value("t3 dbz set", 32'(div_by_zero), 32'd1);
        check_value("t3 done c1", 32'(done), 32'd1);
        check_value("t3 busy c1", 32'(busy), 32'd0);
        check_output("t3 divu/0");
        check_value("t3 dbz sticky", 32'(div_by_zero), 32'd1);
        apply_stimulus(OP_MULT, 32'd6, 32'hFFFF_FFFB, 1'b1);
        tick();
        start = 1'b0;
        check_value("t3 dbz cleared", 32'(div_by_zero), 32'd0);
        finish_op("t3 mult");

        // Test 4: stalled hilo_read and a held back-to-back MULT
        apply_stimulus(OP_MULT, 32'd5, 32'hFFFF_FFF7, 1'b1);
        tick();
        start = 1'b0;
        for (int c = 1; c <= 34; c++) begin
            if (c == 2) apply_stimulus(OP_MULT, 32'h0001_0003, 32'h7FFF_FFFF, 1'b1);
            if (c == 5) begin
                hilo_read = 1'b1;
                hilo_sel  = 1'b1;
            end
            #1;
            if (c >= 2) check_value($sformatf("t4 stall c%0d", c), 32'(mult_div_stall), 32'(c <= 33));
            if (c == 33) check_value("t4 done", 32'(done), 32'd1);
            if (c == 34) begin
                check_value("t4 busy c34", 32'(busy), 32'd0);
                e = exp_q.pop_front();
                check_value("t4 hi on read", hilo_rdata, e[63:32]);
                hilo_sel = 1'b0;
                #1;
                check_value("t4 lo", hilo_rdata, e[31:0]);
                last_hi = e[63:32];
                last_lo = e[31:0];
            end
            if (c < 34) tick();
        end
        tick();
        start     = 1'b0;
        hilo_read = 1'b0;
        check_value("t4 second accepted", 32'(busy), 32'd1);
        finish_op("t4 second mult");

        // Test 5: flush mid-divide, then MTLO
        apply_stimulus(OP_DIV, 32'd1000, 32'd3, 1'b0);
        tick();
        start = 1'b0;
        for (int c = 1; c < 10; c++) begin
            check_value($sformatf("t5 no done c%0d", c), 32'(done), 32'd0);
            tick();
        end
        check_value("t5 busy c10", 32'(busy), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_value("t5 busy c11", 32'(busy), 32'd0);
        check_value("t5 done c11", 32'(done), 32'd0);
        hilo_sel = 1'b1;
        #1;
        check_value("t5 hi kept", hilo_rdata, last_hi);
        hilo_sel = 1'b0;
        #1;
        check_value("t5 lo kept", hilo_rdata, last_lo);
        apply_stimulus(OP_MTLO, 32'h0000_1234, 32'h0, 1'b0);
        tick();
        start = 1'b0;
        check_value("t5 mtlo lo", hilo_rdata, 32'h0000_1234);
        check_value("t5 mtlo busy", 32'(busy), 32'd0);
        check_value("t5 mtlo done", 32'(done), 32'd0);
        hilo_sel = 1'b1;
        #1;
        check_value("t5 mtlo hi", hilo_rdata, last_hi);
        hilo_sel = 1'b0;
        last_lo = 32'h0000_1234;

        // Flush in IDLE blocks a start; reserved op is ignored
        flush = 1'b1;
        apply_stimulus(OP_MTHI, 32'hDEAD_BEEF, 32'h0, 1'b0);
        tick();
        start = 1'b0;
        flush = 1'b0;
        hilo_sel = 1'b1;
        #1;
        check_value("idle flush hi", hilo_rdata, last_hi);
        hilo_sel = 1'b0;
        apply_stimulus(3'd6, 32'hCAFE_F00D, 32'd1, 1'b0);
        tick();
        start = 1'b0;
        check_value("reserved busy", 32'(busy), 32'd0);
        check_value("reserved lo", hilo_rdata, last_lo);
        apply_stimulus(OP_MTHI, 32'hA5A5_0F0F, 32'h0, 1'b0);
        tick();
        start = 1'b0;
        hilo_sel = 1'b1;
        #1;
        check_value("mthi hi", hilo_rdata, 32'hA5A5_0F0F);
        hilo_sel = 1'b0;

        // Test 6: async reset mid-multiply (dbz set first so its clearing is visible)
        run_op(OP_DIV, 32'hFFFF_FF00, 32'd0, "t6 pre div/0");
        apply_stimulus(OP_MULT, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        tick();
        start = 1'b0;
        for (int c = 1; c < 15; c++) tick();
        check_value("t6 busy c15", 32'(busy), 32'd1);
        hilo_read = 1'b1;
        reset_n = 1'b0;
        #1;
        check_value("t6 rst lo", hilo_rdata, 32'h0);
        check_value("t6 rst busy", 32'(busy), 32'd0);
        check_value("t6 rst stall", 32'(mult_div_stall), 32'd0);
        check_value("t6 rst done", 32'(done), 32'd0);
        check_value("t6 rst dbz", 32'(div_by_zero), 32'd0);
        hilo_sel = 1'b1;
        #1;
        check_value("t6 rst hi", hilo_rdata, 32'h0);
        hilo_sel  = 1'b0;
        hilo_read = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        run_op(OP_MULT, 32'h1234_5678, 32'h9ABC_DEF0, "t6 after reset");

        check_value("queue drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
